// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, tuple field layout and latency of the 3-stage arithmetic pipe.
package pipe_pkg;
    localparam int DEFAULT_N    = 10;
    localparam int TUPLE_W      = 4 * DEFAULT_N;
    localparam int A_OFF        = 0;
    localparam int B_OFF        = 1;
    localparam int C_OFF        = 2;
    localparam int D_OFF        = 3;
    localparam int PIPE_LATENCY = 3;
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: LATENCY-deep 1-bit shift register, q is d delayed by LATENCY clock edges.
module valid_delay_line #(
    parameter int LATENCY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [LATENCY-1:0] v;
    always_ff @(posedge clk or posedge rst)
        if (rst) v <= '0;
        else     v <= (v << 1) | LATENCY'(d);
    assign q = v[LATENCY-1];
endmodule

// File: rtl/pipe_operand_feeder.sv
// pipe_operand_feeder: FIFO-buffered operand issue stage for the arithmetic pipe with valid tracking.
// Define FEEDER_STATS_EN to add the issued_cnt / stall_cnt counters.
module pipe_operand_feeder
    import pipe_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int DEPTH   = 4,
    parameter int LATENCY = PIPE_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_a,
    input  logic [N-1:0]           in_b,
    input  logic [N-1:0]           in_c,
    input  logic [N-1:0]           in_d,
    input  logic                   issue_en,
    output logic [N-1:0]           a_o,
    output logic [N-1:0]           b_o,
    output logic [N-1:0]           c_o,
    output logic [N-1:0]           d_o,
    output logic                   out_valid,
    output logic                   f_valid,
`ifdef FEEDER_STATS_EN
    output logic [15:0]            issued_cnt,
    output logic [15:0]            stall_cnt,
`endif
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [4*N-1:0] mem [DEPTH];
    logic [4*N-1:0] wr_tuple, head;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic           push, pop;
    assign in_ready = count < CW'(DEPTH);
    assign push     = in_valid & in_ready;
    assign pop      = issue_en & (count != '0);
    assign head     = mem[rd_ptr];
    always_comb begin
        wr_tuple = '0;
        wr_tuple[A_OFF*N +: N] = in_a;
        wr_tuple[B_OFF*N +: N] = in_b;
        wr_tuple[C_OFF*N +: N] = in_c;
        wr_tuple[D_OFF*N +: N] = in_d;
    end
    // storage is deliberately left out of reset; pointers alone define validity
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_tuple;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            a_o       <= '0;
            b_o       <= '0;
            c_o       <= '0;
            d_o       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                a_o    <= head[A_OFF*N +: N];
                b_o    <= head[B_OFF*N +: N];
                c_o    <= head[C_OFF*N +: N];
                d_o    <= head[D_OFF*N +: N];
            end
            out_valid <= pop;
            count     <= count + CW'(push) - CW'(pop);
        end
    valid_delay_line #(.LATENCY(LATENCY)) u_vdl (
        .clk (clk),
        .rst (rst),
        .d   (out_valid),
        .q   (f_valid)
    );
`ifdef FEEDER_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (pop) issued_cnt <= issued_cnt + 16'd1;
            if ((count != '0) && !issue_en) stall_cnt <= stall_cnt + 16'd1;
        end
`endif
endmodule

// File: tb/tb_pipe_operand_feeder.sv
// tb_pipe_operand_feeder: scoreboard bench for pipe_operand_feeder with a reference model of the arithmetic pipe.
module tb_pipe_operand_feeder;
    import pipe_pkg::*;
    localparam int N = DEFAULT_N;
    localparam int DEPTH = 4;
    localparam int LAT = PIPE_LATENCY;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, issue_en = 1'b0;
    logic in_ready, out_valid, f_valid;
    logic [N-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic [N-1:0] a_o, b_o, c_o, d_o;
    logic [$clog2(DEPTH):0] count;
`ifdef FEEDER_STATS_EN
    logic [15:0] issued_cnt, stall_cnt;
`endif
    pipe_operand_feeder #(.N(N), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .issue_en(issue_en),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o),
        .out_valid(out_valid), .f_valid(f_valid),
`ifdef FEEDER_STATS_EN
        .issued_cnt(issued_cnt), .stall_cnt(stall_cnt),
`endif
        .count(count)
    );
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    logic [TUPLE_W-1:0] tq[$];
    logic [N-1:0] fq[$];
    logic [N-1:0] f_seen[$];
    int mcount = 0, issues = 0, stalls = 0;
    logic exp_ov = 1'b0;
    logic [LAT-1:0] mv = '0;
    // reference pipe: f = ((a+b)+(c-d))*d, updating LAT edges after a tuple appears on a_o..d_o
    logic [N-1:0] p1s, p1c, p1d, p2s, p2d, pf;
    always @(posedge clk) begin
        p1s <= a_o + b_o;
        p1c <= c_o - d_o;
        p1d <= d_o;
        p2s <= p1s + p1c;
        p2d <= p1d;
        pf  <= p2s * p2d;
    end
    function automatic logic [N-1:0] fcalc(input logic [N-1:0] a, b, c, d);
        return ((a + b) + (c - d)) * d;
    endfunction
    // scoreboard monitor: compares the state left by the last edge, then predicts the next edge
    always @(negedge clk) begin
        logic psh, pp;
        logic [TUPLE_W-1:0] t;
        logic [N-1:0] ef;
        if (rst) begin
            mcount = 0; exp_ov = 1'b0; mv = '0; issues = 0; stalls = 0;
            tq.delete(); fq.delete();
        end else begin
            checks++;
            if (count !== mcount) begin failures++; $display("FAIL count: got %0d want %0d t=%0t", count, mcount, $time); end
            checks++;
            if (in_ready !== (mcount < DEPTH)) begin failures++; $display("FAIL in_ready: got %b want %b t=%0t", in_ready, mcount < DEPTH, $time); end
            checks++;
            if (out_valid !== exp_ov) begin failures++; $display("FAIL out_valid: got %b want %b t=%0t", out_valid, exp_ov, $time); end
            checks++;
            if (f_valid !== mv[LAT-1]) begin failures++; $display("FAIL f_valid: got %b want %b t=%0t", f_valid, mv[LAT-1], $time); end
            if (out_valid === 1'b1) begin
                checks++;
                if (tq.size() == 0) begin failures++; $display("FAIL tuple: got unexpected issue t=%0t", $time); end
                else begin
                    t = tq.pop_front();
                    if ({d_o, c_o, b_o, a_o} !== t) begin
                        failures++;
                        $display("FAIL tuple: got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d t=%0t", a_o, b_o, c_o, d_o,
                                 t[N-1:0], t[2*N-1:N], t[3*N-1:2*N], t[4*N-1:3*N], $time);
                    end
                end
            end
            if (f_valid === 1'b1) begin
                f_seen.push_back(pf);
                checks++;
                if (fq.size() == 0) begin failures++; $display("FAIL f: got unexpected result %0d t=%0t", pf, $time); end
                else begin
                    ef = fq.pop_front();
                    if (pf !== ef) begin failures++; $display("FAIL f: got %0d want %0d t=%0t", pf, ef, $time); end
                end
            end
            psh = in_valid && (mcount < DEPTH);
            pp  = issue_en && (mcount != 0);
            if (psh) begin
                tq.push_back({in_d, in_c, in_b, in_a});
                fq.push_back(fcalc(in_a, in_b, in_c, in_d));
            end
            if (pp) issues++;
            if (!issue_en && mcount != 0) stalls++;
            mcount = mcount + int'(psh) - int'(pp);
            mv = {mv[LAT-2:0], exp_ov};
            exp_ov = pp;
        end
    end
    task automatic drive(input logic v, input logic en, input logic [N-1:0] a, b, c, d);
        @(posedge clk); #1;
        in_valid = v; issue_en = en; in_a = a; in_b = b; in_c = c; in_d = d;
    endtask
    task automatic drain();
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40 && (mcount != 0 || tq.size() != 0 || fq.size() != 0); i++) @(posedge clk);
        repeat (LAT + 1) @(posedge clk);
        #1;
        checks++;
        if (tq.size() != 0 || fq.size() != 0) begin
            failures++; $display("FAIL drain: got %0d tuples / %0d results pending want 0", tq.size(), fq.size());
        end
    endtask
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; issue_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 0 || in_ready !== 1'b1 || out_valid !== 1'b0 || f_valid !== 1'b0) begin
            failures++; $display("FAIL reset_ctl: got count=%0d rdy=%b ov=%b fv=%b want 0 1 0 0", count, in_ready, out_valid, f_valid);
        end
        checks++;
        if ({a_o, b_o, c_o, d_o} !== '0) begin
            failures++; $display("FAIL reset_ops: got %0d,%0d,%0d,%0d want 0,0,0,0", a_o, b_o, c_o, d_o);
        end
    endtask
    task automatic test_stream();
        logic [N-1:0] want[4] = '{10'd52, 10'd66, 10'd112, 10'd58};
        f_seen.delete();
        drive(1, 1, 10, 12, 6, 2);
        drive(1, 1, 10, 10, 5, 3);
        drive(1, 1, 20, 11, 1, 4);
        drive(1, 1, 12, 15, 4, 2);
        drain();
        checks++;
        if (f_seen.size() != 4) begin failures++; $display("FAIL stream_n: got %0d results want 4", f_seen.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (f_seen[i] !== want[i]) begin failures++; $display("FAIL stream_f%0d: got %0d want %0d", i, f_seen[i], want[i]); end
        end
    endtask
    task automatic test_fill();
        for (int i = 0; i < 5; i++) drive(1, 0, N'(i + 1), N'(i + 2), N'(i + 3), N'(i));
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (count !== 4 || in_ready !== 1'b0) begin failures++; $display("FAIL fill: got count=%0d rdy=%b want 4 0", count, in_ready); end
        drive(0, 1, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (count !== 0 || in_ready !== 1'b1) begin failures++; $display("FAIL fill_drain: got count=%0d rdy=%b want 0 1", count, in_ready); end
        drain();
    endtask
    task automatic test_full_pushpop();
        for (int i = 0; i < 4; i++) drive(1, 0, N'(100 + i), N'(i), N'(7), N'(3));
        drive(1, 1, 200, 1, 2, 3);
        @(posedge clk); #1;
        checks++;
        if (count !== 3) begin failures++; $display("FAIL full_nopush: got count=%0d want 3", count); end
        @(posedge clk); #1;
        checks++;
        if (count !== 3) begin failures++; $display("FAIL full_pushpop: got count=%0d want 3", count); end
        drain();
    endtask
    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) drive(1, 0, N'(30 + i), N'(i), N'(9), N'(1));
        drive(0, 1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; issue_en = 1'b0;
        #1;
        checks++;
        if (count !== 0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid: got count=%0d ov=%b want 0 0", count, out_valid); end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (f_valid !== 1'b0) begin failures++; $display("FAIL rst_fvalid%0d: got %b want 0", i, f_valid); end
        end
    endtask
    task automatic test_wrap();
        int sent = 0;
        for (int cyc = 0; cyc < 200 && sent < 10; cyc++) begin
            @(posedge clk); #1;
            issue_en = cyc[0];
            in_valid = 1'b0;
            if (mcount < DEPTH) begin
                in_valid = 1'b1;
                in_a = N'($urandom); in_b = N'($urandom); in_c = N'($urandom); in_d = N'($urandom);
                sent++;
            end
        end
        checks++;
        if (sent != 10) begin failures++; $display("FAIL wrap_send: got %0d pushes want 10", sent); end
        drain();
`ifdef FEEDER_STATS_EN
        checks++;
        if (issued_cnt !== 16'd10) begin failures++; $display("FAIL issued_cnt: got %0d want 10", issued_cnt); end
        checks++;
        if (stall_cnt !== 16'(stalls)) begin failures++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, stalls); end
`endif
    endtask
    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_full_pushpop();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_operand_feeder.md
Name: pipe_operand_feeder

Overview:
Upstream issue stage for the 3-stage arithmetic pipe, which computes f = ((a+b)+(c-d))*d and has no stall or valid signalling.
- Buffers operand tuples {a,b,c,d} from a valid/ready producer in a small FIFO.
- Issues at most one tuple per clock into the pipe on registered outputs.
- Tracks pipe latency with a valid shift register, so f_valid marks which pipe results are meaningful.

Parameters:
N, 10, operand/result width in bits (matches the pipe)
DEPTH, 4, FIFO depth in tuples; power of 2, >= 2
LATENCY, 3, clock edges from the pipe capturing a tuple to f updating; >= 1

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  producer has a tuple on in_a..in_d
in_ready  out  1  feeder can accept a tuple this cycle
in_a, in_b, in_c, in_d  in  N each  operand tuple from the producer
issue_en  in  1  issue permission; low blocks issue
a_o, b_o, c_o, d_o  out  N each  operands to the pipe (registered)
out_valid  out  1  a_o..d_o hold a newly issued tuple this cycle
f_valid  out  1  the pipe's f corresponds to an issued tuple this cycle
count  out  $clog2(DEPTH)+1  tuples currently buffered

Behaviour:
- Reset (async assert, any time including mid-operation):
  - Pointers, count, out_valid and every bit of the valid shift register go to 0.
  - a_o..d_o go to 0 and f_valid goes to 0.
  - FIFO storage is not cleared.
  - Results of tuples already inside the pipe are discarded; they never raise f_valid.
- Push:
  - in_ready = (count < DEPTH); driven from registered count only.
  - A push happens when in_valid & in_ready at a rising edge; the tuple is written at wr_ptr and wr_ptr increments (wraps mod DEPTH).
  - When full, in_ready is 0 and no write occurs. A pop in the same cycle does not free a slot for that cycle.
- Issue/pop:
  - Issue happens when issue_en & (count != 0) at a rising edge.
  - On issue: the head tuple is registered into a_o..d_o, out_valid <= 1, and rd_ptr increments (wraps).
  - Otherwise: out_valid <= 0 and a_o..d_o hold their last values.
- Empty behaviour:
  - No bypass: a tuple pushed at edge t issues at edge t+1 at the earliest (1-cycle latency when empty and issue_en=1).
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - count never exceeds DEPTH and never underflows.
- Valid tracking:
  - v[0] <= out_valid; v[i] <= v[i-1]; f_valid = v[LATENCY-1].
  - A tuple issued at edge k gives f_valid high after edge k+LATENCY, for exactly one cycle per tuple.
- Throughput:
  - Back-to-back pushes with issue_en=1 sustain 1 tuple/clock with count steady at <= 1.
- Data:
  - Operands pass through unmodified; no arithmetic is done in this block.

Optional Feature:
FEEDER_STATS_EN:
- Defined: adds output issued_cnt (16 bits), reset 0, +1 per issue, wraps 0xFFFF->0.
- Defined: adds output stall_cnt (16 bits), +1 each cycle with count != 0 and issue_en = 0, wraps.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Package pipe_pkg:
  - default N
  - tuple width TUPLE_W = 4*N
  - field offsets for a/b/c/d within the packed tuple
  - PIPE_LATENCY = 3
- Sub-module valid_delay_line:
  - Parameter LATENCY, async active-high reset, 1-bit in/out shift register.
  - Reused later for result-side valid tracking.
- FIFO storage and pointers stay inline.

Test Plan:
1. Reset then idle -> count=0, in_ready=1, out_valid=0, f_valid=0, a_o..d_o=0.
2. Pushes on consecutive cycles, issue_en=1, through the feeder and pipe:
   - (10,12,6,2), (10,10,5,3), (20,11,1,4), (12,15,4,2)
   - Each tuple appears on a_o..d_o one edge after its push.
   - f_valid pulses with f = 52, 66, 112, 58 in order, each 3 edges after its issue.
3. issue_en=0, push 5 tuples:
   - count climbs 1..4, in_ready drops after the 4th push, and the 5th tuple is not accepted.
   - Raise issue_en: 4 consecutive issues in FIFO order, then in_ready returns to 1.
4. Full FIFO, in_valid=1 with issue_en=1:
   - No push in the cycle in_ready=0.
   - Next cycle push and pop together, count holds at 3.
5. Assert rst while 2 tuples are buffered and 2 are in the pipe:
   - count=0 and out_valid=0 immediately.
   - f_valid stays 0 for the following 4 cycles.
6. Wrap-around: push/pop 10 tuples with alternating issue_en (pointers wrap twice) -> output order matches input order exactly.
   - With FEEDER_STATS_EN defined, issued_cnt=10 and stall_cnt equals the number of blocked cycles.
